rob_retire: RTL
===============

# rob_retire

In-order commit stage at the read (head) end of the reorder buffer; the `rob` block owns allocation. Each cycle it inspects the ROB head entry. Ready ALU/load results are retired to the register file, ready stores are released to the store buffer under a valid/ready handshake, and excepting entries trigger a pipeline flush and redirect. Sits between `rob` (head port), the register file write port and the store buffer.

## Interface
- `WORD_SIZE`, `` `WORD_SIZE `` (32): data/PC width
- `ROB_ENTRIES`, 10: ROB depth; sets `IDX_W = $clog2(ROB_ENTRIES)`
- `REG_ADDR_W`, 5: architectural register address width
- `EXC_VECTOR`, 32'h0000_0100: redirect target on exception

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `head_valid`  in  1  ROB head entry occupied
- `head_ready`  in  1  head result complete (`entry_ready[head]`)
- `head_idx`  in  IDX_W  head index (debug/trace only)
- `head_pc`  in  WORD_SIZE  head instruction PC
- `head_dest`  in  REG_ADDR_W  destination register
- `head_value`  in  WORD_SIZE  result value
- `head_is_store`  in  1  head is a store
- `head_exc`  in  1  head raised an exception
- `head_cause`  in  4  exception cause
- `pop`  out  1  combinational; ROB advances head on this edge
- `rf_we` / `rf_waddr` / `rf_wdata`  out  1 / REG_ADDR_W / WORD_SIZE  registered RF write
- `sb_commit_valid`  out  1  registered; release oldest store
- `sb_commit_ready`  in  1  store buffer accepts
- `flush`  out  1  registered one-cycle pulse
- `redirect_pc` / `epc` / `cause`  out  WORD_SIZE / WORD_SIZE / 4  valid with `flush`, held until next flush
- `retired_count`  out  32  committed-instruction counter

## Operation
- FSM states: RUN, STORE_WAIT, FLUSH. Reset state is RUN.
- RUN, head not (`head_valid & head_ready`): idle, `pop=0`.
- RUN, ready non-store, no exc:
  - `pop=1`.
  - Next cycle `rf_we=1`, with `rf_waddr=head_dest` and `rf_wdata=head_value`.
  - Suppressed (`rf_we=0`) when `head_dest==0`.
  - `retired_count++`.
- RUN, ready store, no exc:
  - `pop=0`.
  - `sb_commit_valid` set next cycle, then go to STORE_WAIT.
- STORE_WAIT:
  - Hold `sb_commit_valid=1` until `sb_commit_ready`.
  - On the handshake cycle, `pop=1` and `retired_count++`.
  - `sb_commit_valid` drops next cycle; return to RUN.
- RUN, ready with `head_exc` (store or not):
  - `pop=0`.
  - Next cycle `flush=1`, `redirect_pc=EXC_VECTOR`, `epc=head_pc`, `cause=head_cause`.
  - Go to FLUSH.
- FLUSH:
  - `pop=0`.
  - Ignore head for one cycle, since the ROB clears itself on `flush`.
  - Return to RUN.
- Excepting entries are never counted and never written to RF.
- At most one retire per cycle. `pop` is never asserted in FLUSH or in the cycle after a store enters STORE_WAIT.
- `retired_count` wraps modulo 2^32.

## Timing
- Reset (`rst=0`, async): every output is 0 (`pop`, `rf_*`, `sb_commit_valid`, `flush`, `redirect_pc`, `epc`, `cause`, `retired_count`), and the FSM is in RUN.
- Reset asserted in STORE_WAIT abandons the pending store; the store buffer sees `sb_commit_valid` fall asynchronously.
- `pop` depends only on current state and head inputs. It is never asserted while `rst=0`.
- RF write latency: 1 cycle after `pop`. Back-to-back ready ALU heads retire one per cycle.
- Store latency: ≥2 cycles (valid set, then handshake). `sb_commit_valid` must not drop before `sb_commit_ready`.
- `head_*` must be stable while in STORE_WAIT. The head cannot change because `pop=0`.
- `head_ready` rising in the same cycle as `head_valid` qualifies immediately.

## Structure
- Shared package `rob_pkg`:
  - `retire_state_t` enum (RUN, STORE_WAIT, FLUSH)
  - `exc_cause_t` (4-bit)
  - `EXC_VECTOR` default
  - `rob_head_t` struct (pc, dest, value, is_store, exc, cause)
- No sub-module needed. The counter and FSM are inline. `rob` instantiates `rob_retire` and drives its head fields.

## Test plan
- Reset mid-stream: `rst=0` while in STORE_WAIT -> all outputs 0 immediately, FSM in RUN, `retired_count=0`.
- Three ready ALU heads (dest 3, 4, 0; values 0x11, 0x22, 0x33) -> `pop` three consecutive cycles; `rf_we` writes r3=0x11 and r4=0x22; no write for r0; count=3.
- Head valid but not ready for 5 cycles, then ready -> `pop=0` for 5 cycles, single pop on the ready cycle.
- Ready store with `sb_commit_ready` held low 3 cycles -> `sb_commit_valid` high 4 cycles, `pop` only on the handshake cycle, count+1.
- Excepting head (pc 0x40, cause 2) -> `flush=1` for exactly one cycle, `redirect_pc=0x100`, `epc=0x40`, `cause=2`, no pop, no RF write, count unchanged.
- Counter preset to 0xFFFF_FFFF by force, one retire -> `retired_count=0`.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared types and constants for the reorder buffer and its
// commit stage.
//   retire_state_t     - commit FSM states (RUN, STORE_WAIT, FLUSH)
//   exc_cause_t        - 4-bit exception cause code
//   DEFAULT_EXC_VECTOR - default redirect target taken on an exception
//   rob_head_t         - fields the ROB presents for its head entry
package rob_pkg;

  typedef enum logic [1:0] {
    RUN,
    STORE_WAIT,
    FLUSH
  } retire_state_t;

  typedef logic [3:0] exc_cause_t;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] value;
    logic        is_store;
    logic        exc;
    exc_cause_t  cause;
  } rob_head_t;

endpackage

// File: rtl/rob_retire.sv
// rob_retire: in-order commit stage at the head of the reorder buffer.
// Each cycle it looks at the ROB head entry and does one of three things:
//   - ALU/load results are retired to the register file.
//   - Stores are released to the store buffer with a valid/ready handshake.
//   - Excepting entries raise a flush and redirect.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   head_valid/head_ready        head entry occupied / result complete
//   head_idx                     head index (trace only)
//   head_pc/dest/value           head instruction PC, dest reg, result
//   head_is_store/exc/cause      store flag, exception flag, cause
//   pop                          combinational; ROB advances its head
//   rf_we/rf_waddr/rf_wdata      registered register-file write
//   sb_commit_valid/ready        store release handshake
//   flush                        registered one-cycle flush pulse
//   redirect_pc/epc/cause        exception info, held until next flush
//   retired_count                committed-instruction counter
module rob_retire
  import rob_pkg::*;
#(
  parameter int                    WORD_SIZE   = 32,
  parameter int                    ROB_ENTRIES = 10,
  parameter int                    REG_ADDR_W  = 5,
  parameter logic [WORD_SIZE-1:0]  EXC_VECTOR  = DEFAULT_EXC_VECTOR,
  localparam int                   IDX_W       = $clog2(ROB_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  head_valid,
  input  logic                  head_ready,
  input  logic [IDX_W-1:0]      head_idx,
  input  logic [WORD_SIZE-1:0]  head_pc,
  input  logic [REG_ADDR_W-1:0] head_dest,
  input  logic [WORD_SIZE-1:0]  head_value,
  input  logic                  head_is_store,
  input  logic                  head_exc,
  input  logic [3:0]            head_cause,
  output logic                  pop,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]  rf_wdata,
  output logic                  sb_commit_valid,
  input  logic                  sb_commit_ready,
  output logic                  flush,
  output logic [WORD_SIZE-1:0]  redirect_pc,
  output logic [WORD_SIZE-1:0]  epc,
  output logic [3:0]            cause,
  output logic [31:0]           retired_count
);

  retire_state_t state, state_nx;

  logic head_go;
  logic alu_retire;
  logic store_start;
  logic store_done;
  logic exc_start;

  // The head index is carried for tracing only.
  logic unused_head_idx;
  assign unused_head_idx = ^head_idx;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and commit decisions. An exception takes priority over the
  // store/ALU distinction, so an excepting store is never released. pop is
  // forced low while reset is held so the ROB cannot advance during reset.
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    head_go     = head_valid & head_ready;
    alu_retire  = 1'b0;
    store_start = 1'b0;
    store_done  = 1'b0;
    exc_start   = 1'b0;
    case (state)
      RUN: begin
        if (head_go) begin
          if (head_exc) begin
            exc_start = 1'b1;
            state_nx  = FLUSH;
          end else if (head_is_store) begin
            store_start = 1'b1;
            state_nx    = STORE_WAIT;
          end else begin
            alu_retire = 1'b1;
            pop        = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        if (sb_commit_valid && sb_commit_ready) begin
          store_done = 1'b1;
          pop        = 1'b1;
          state_nx   = RUN;
        end
      end
      FLUSH: begin
        state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
    if (!rst) begin
      pop = 1'b0;
    end
  end

  // Registered commit outputs. Writes to r0 are dropped but still count as
  // retired. The exception fields only load on a new exception, so they
  // stay readable after the flush pulse has gone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      sb_commit_valid <= 1'b0;
      flush           <= 1'b0;
      redirect_pc     <= '0;
      epc             <= '0;
      cause           <= '0;
      retired_count   <= '0;
    end else begin
      rf_we <= alu_retire && (head_dest != '0);
      if (alu_retire) begin
        rf_waddr <= head_dest;
        rf_wdata <= head_value;
      end
      if (store_start) begin
        sb_commit_valid <= 1'b1;
      end else if (store_done) begin
        sb_commit_valid <= 1'b0;
      end
      flush <= exc_start;
      if (exc_start) begin
        redirect_pc <= EXC_VECTOR;
        epc         <= head_pc;
        cause       <= head_cause;
      end
      if (pop) begin
        retired_count <= retired_count + 32'd1;
      end
    end
  end

endmodule
